// File: rtl/decode_stage_pkg.sv
// Shared decode types: ALU operation codes, operand selects, opcodes and the decoded bundle.
package decode_stage_pkg;

  typedef enum logic [5:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JAL, ALU_JALR, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_e;

  typedef enum logic [1:0] {OP_TYPE_NONE, OP_TYPE_REG, OP_TYPE_IMM, OP_TYPE_PC} op_type_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} buf_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_e        alucode;
    op_type_e    op1;
    op_type_e    op2;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        is_illegal;
  } dec_t;

  // Integer ALU op for OP/OP-IMM funct3; alt selects SUB/SRA (funct7[5]).
  function automatic alu_e alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I decoder, ir -> dec_t; no state, no handshake.
// RV32M_EN defined: funct7=0000001 OP encodings decode to MUL..REMU, otherwise illegal.
module rv_decode_comb
  import decode_stage_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;
  dec_t        d;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign funct7 = ir_i[31:25];
  assign imm_i  = {{20{ir_i[31]}}, ir_i[31:20]};
  assign imm_sh = {27'b0, ir_i[24:20]};
  assign imm_s  = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
  assign imm_b  = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign imm_u  = {ir_i[31:12], 12'b0};
  assign imm_j  = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

  always_comb begin
    d       = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d.rd = ir_i[11:7]; d.imm = imm_u; d.op1 = OP_TYPE_NONE; d.op2 = OP_TYPE_IMM;
        d.alucode = ALU_ADD; d.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        d.rd = ir_i[11:7]; d.imm = imm_u; d.op1 = OP_TYPE_PC; d.op2 = OP_TYPE_IMM;
        d.alucode = ALU_ADD; d.reg_we = 1'b1;
      end
      OPC_JAL: begin
        d.rd = ir_i[11:7]; d.imm = imm_j; d.op1 = OP_TYPE_PC; d.op2 = OP_TYPE_IMM;
        d.alucode = ALU_JAL; d.reg_we = 1'b1;
      end
      OPC_JALR: begin
        d.rs1 = ir_i[19:15]; d.rd = ir_i[11:7]; d.imm = imm_i; d.op1 = OP_TYPE_REG;
        d.op2 = OP_TYPE_IMM; d.alucode = ALU_JALR; d.reg_we = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.rs1 = ir_i[19:15]; d.rs2 = ir_i[24:20]; d.imm = imm_b;
        d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_REG;
        case (funct3)
          3'b000:  d.alucode = ALU_BEQ;
          3'b001:  d.alucode = ALU_BNE;
          3'b100:  d.alucode = ALU_BLT;
          3'b101:  d.alucode = ALU_BGE;
          3'b110:  d.alucode = ALU_BLTU;
          3'b111:  d.alucode = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.rs1 = ir_i[19:15]; d.rd = ir_i[11:7]; d.imm = imm_i; d.op1 = OP_TYPE_REG;
        d.op2 = OP_TYPE_IMM; d.alucode = ALU_ADD; d.reg_we = 1'b1; d.is_load = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d.rs1 = ir_i[19:15]; d.rs2 = ir_i[24:20]; d.imm = imm_s; d.op1 = OP_TYPE_REG;
        d.op2 = OP_TYPE_IMM; d.alucode = ALU_ADD; d.is_store = 1'b1;
        illegal = (funct3[2] || (funct3[1:0] == 2'b11));
      end
      OPC_OPIMM: begin
        d.rs1 = ir_i[19:15]; d.rd = ir_i[11:7]; d.imm = imm_i; d.op1 = OP_TYPE_REG;
        d.op2 = OP_TYPE_IMM; d.reg_we = 1'b1; d.alucode = alu_f3(funct3, 1'b0);
        if (funct3 == 3'b001) begin
          d.imm = imm_sh;
          illegal = (funct7 != 7'b0);
        end else if (funct3 == 3'b101) begin
          d.imm = imm_sh;
          d.alucode = alu_f3(funct3, funct7[5]);
          illegal = ({funct7[6], funct7[4:0]} != 6'b0);
        end
      end
      OPC_OP: begin
        d.rs1 = ir_i[19:15]; d.rs2 = ir_i[24:20]; d.rd = ir_i[11:7];
        d.op1 = OP_TYPE_REG; d.op2 = OP_TYPE_REG; d.reg_we = 1'b1;
        if (funct7 == 7'b0000000) d.alucode = alu_f3(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          d.alucode = alu_f3(funct3, 1'b1);
`ifdef RV32M_EN
        else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000:  d.alucode = ALU_MUL;
            3'b001:  d.alucode = ALU_MULH;
            3'b010:  d.alucode = ALU_MULHSU;
            3'b011:  d.alucode = ALU_MULHU;
            3'b100:  d.alucode = ALU_DIV;
            3'b101:  d.alucode = ALU_DIVU;
            3'b110:  d.alucode = ALU_REM;
            default: d.alucode = ALU_REMU;
          endcase
        end
`endif
        else illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        // Only ECALL/EBREAK are supported; both stop the pipeline.
        if (ir_i == 32'h0000_0073 || ir_i == 32'h0010_0073) d.is_halt = 1'b1;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      d            = '0;
      d.is_illegal = 1'b1;
      d.is_halt    = (HALT_ON_ILLEGAL != 0);
    end
    if (d.rd == 5'd0) d.reg_we = 1'b0;
  end

  assign dec_o = d;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage, 1-cycle latency; 2-entry output/skid buffer keeps full rate under
// backpressure (in_ready drops only when both entries full). RV32M_EN enables M decode.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W            = 32,
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       srcreg1_num,
  output logic [4:0]       srcreg2_num,
  output logic [4:0]       dstreg_num,
  output logic [31:0]      imm,
  output logic [5:0]       alucode,
  output logic [1:0]       aluop1_type,
  output logic [1:0]       aluop2_type,
  output logic             reg_we,
  output logic             is_load,
  output logic             is_store,
  output logic             is_halt,
  output logic             is_illegal,
  output logic [CNT_W-1:0] decoded_cnt
);

  dec_t            in_dec, out_q, out_d, skid_q, skid_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  buf_state_e      state_q, state_d;
  logic            halted_q, halted_d, in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            fire_in, fire_out;

  rv_decode_comb #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_dec (.ir_i(in_ir), .dec_o(in_dec));

  assign fire_in  = in_valid & in_ready_q;
  assign fire_out = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    out_pc_d  = out_pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    halted_d  = halted_q;
    cnt_d     = cnt_q;
    if (fire_out && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    case (state_q)
      ST_EMPTY: if (fire_in) begin
        out_d = in_dec; out_pc_d = in_pc; state_d = ST_ONE;
      end
      ST_ONE: begin
        if (fire_in && !fire_out) begin
          skid_d = in_dec; skid_pc_d = in_pc; state_d = ST_TWO;
        end else if (fire_in) begin
          out_d = in_dec; out_pc_d = in_pc;
        end else if (fire_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (fire_out) begin
        out_d = skid_q; out_pc_d = skid_pc_q; state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    // A retiring halt kills anything younger, buffered or arriving this cycle.
    if (fire_out && out_q.is_halt) begin
      halted_d = 1'b1;
      state_d  = ST_EMPTY;
    end
    if (flush) begin
      halted_d = 1'b0;
      state_d  = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_TWO) && !halted_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      out_pc_q   <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
      halted_q   <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      out_pc_q   <= out_pc_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      halted_q   <= halted_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_pc      = out_pc_q;
  assign srcreg1_num = out_q.rs1;
  assign srcreg2_num = out_q.rs2;
  assign dstreg_num  = out_q.rd;
  assign imm         = out_q.imm;
  assign alucode     = out_q.alucode;
  assign aluop1_type = out_q.op1;
  assign aluop2_type = out_q.op2;
  assign reg_we      = out_q.reg_we;
  assign is_load     = out_q.is_load;
  assign is_store    = out_q.is_store;
  assign is_halt     = out_q.is_halt;
  assign is_illegal  = out_q.is_illegal;
  assign decoded_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, backpressured stream, flush and halt sequences.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  op1, op2;
    logic        we, ld, st, halt, ill;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = '0, in_pc = '0;
  logic        in_ready, out_valid, reg_we, is_load, is_store, is_halt, is_illegal;
  logic [31:0] out_pc, imm, decoded_cnt;
  logic [4:0]  srcreg1_num, srcreg2_num, dstreg_num;
  logic [5:0]  alucode;
  logic [1:0]  aluop1_type, aluop2_type;

  int   tests = 0, fails = 0;
  exp_t q[$];
  exp_t cur_exp, act, mon_e;
  logic mon_halt;

  decode_stage #(.PC_W(32), .CNT_W(32), .HALT_ON_ILLEGAL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num),
    .dstreg_num(dstreg_num), .imm(imm), .alucode(alucode), .aluop1_type(aluop1_type),
    .aluop2_type(aluop2_type), .reg_we(reg_we), .is_load(is_load), .is_store(is_store),
    .is_halt(is_halt), .is_illegal(is_illegal), .decoded_cnt(decoded_cnt)
  );

  always #5 clk = ~clk;

  assign act = {out_pc, srcreg1_num, srcreg2_num, dstreg_num, imm, alucode, aluop1_type,
                aluop2_type, reg_we, is_load, is_store, is_halt, is_illegal};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic [31:0] im, input alu_e a, input op_type_e o1,
                              input op_type_e o2, input logic [4:0] fl);
    exp_t e;
    e.pc = '0; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = im; e.alu = a;
    e.op1 = o1; e.op2 = o2;
    {e.we, e.ld, e.st, e.halt, e.ill} = fl;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // addi xk, x0, 3k at pc 0x2000+4k
  task automatic drive_addi(input int k);
    exp_t e;
    in_ir = {12'(k * 3), 5'd0, 3'b000, 5'(k), 7'b0010011};
    in_pc = 32'h2000 + 32'(k * 4);
    e = mk(5'd0, 5'd0, 5'(k), 32'(k * 3), ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'b10000);
    e.pc = in_pc;
    cur_exp = e;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check(name, q.size(), 0);
  endtask

  // Scoreboard: decide at the negedge what the next posedge will do.
  always @(negedge clk) begin
    mon_halt = 1'b0;
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got bundle pc %0h, required no output", out_pc);
        end else begin
          mon_e = q.pop_front();
          check($sformatf("sb_pc_%0h", mon_e.pc), act, mon_e);
          mon_halt = mon_e.halt;
        end
      end
      if (flush || mon_halt) q.delete();
      else if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  initial begin
    vec_t        tbl[13];
    exp_t        ill, ex;
    int          idx, cyc, mism;
    logic        saw_two;

    ill = mk(0, 0, 0, 0, ALU_NOP, OP_TYPE_NONE, OP_TYPE_NONE, 5'b00011);
    tbl[0]  = '{32'hFFF10093, mk(2, 0, 1, 32'hFFFFFFFF, ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'b10000)};
    tbl[1]  = '{32'hFE208EE3, mk(1, 2, 0, 32'hFFFFFFFC, ALU_BEQ, OP_TYPE_REG, OP_TYPE_REG, 5'b00000)};
    tbl[2]  = '{32'h123452B7, mk(0, 0, 5, 32'h12345000, ALU_ADD, OP_TYPE_NONE, OP_TYPE_IMM, 5'b10000)};
    tbl[3]  = '{32'h00001517, mk(0, 0, 10, 32'h00001000, ALU_ADD, OP_TYPE_PC, OP_TYPE_IMM, 5'b10000)};
    tbl[4]  = '{32'h0020A423, mk(1, 2, 0, 32'd8, ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'b00100)};
    tbl[5]  = '{32'hFFC12183, mk(2, 0, 3, 32'hFFFFFFFC, ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'b11000)};
    tbl[6]  = '{32'h4032D213, mk(5, 0, 4, 32'd3, ALU_SRA, OP_TYPE_REG, OP_TYPE_IMM, 5'b10000)};
    tbl[7]  = '{32'h010000EF, mk(0, 0, 1, 32'd16, ALU_JAL, OP_TYPE_PC, OP_TYPE_IMM, 5'b10000)};
    tbl[8]  = '{32'h00208033, mk(1, 2, 0, 32'd0, ALU_ADD, OP_TYPE_REG, OP_TYPE_REG, 5'b00000)};
`ifdef RV32M_EN
    tbl[9]  = '{32'h02208033, mk(1, 2, 0, 32'd0, ALU_MUL, OP_TYPE_REG, OP_TYPE_REG, 5'b00000)};
`else
    tbl[9]  = '{32'h02208033, ill};
`endif
    tbl[10] = '{32'hFE20AEE3, ill};
    tbl[11] = '{32'hFFFFFFFF, ill};
    tbl[12] = '{32'h00000073, mk(0, 0, 0, 32'd0, ALU_NOP, OP_TYPE_NONE, OP_TYPE_NONE, 5'b00010)};

    // Reset state
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cnt", decoded_cnt, 32'd0);
    check("rst_bundle", act, '0);
    rst = 1'b0;
    step();

    // Stream of 8 with a 3-cycle stall mid-burst
    idx = 0; cyc = 0; mism = 0; saw_two = 1'b0;
    while ((idx < 8 || q.size() != 0) && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      if (in_ready !== (q.size() != 2)) mism++;
      if (!in_ready) saw_two = 1'b1;
      if (in_ready && idx < 8) begin
        drive_addi(idx + 1);
        in_valid = 1'b1;
        idx++;
      end else in_valid = 1'b0;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_done", (idx == 8) && (q.size() == 0), 1'b1);
    check("stream_rdy_only_two", mism, 0);
    check("stream_saw_two", saw_two, 1'b1);
    check("stream_cnt", decoded_cnt, 32'd8);

    // Flush from TWO with in_valid high
    out_ready = 1'b0;
    for (int k = 20; k < 22; k++) begin
      drive_addi(k);
      in_valid = 1'b1;
      step();
    end
    check("flush_pre_rdy", in_ready, 1'b0);
    drive_addi(22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_two_vld", out_valid, 1'b0);
    check("flush_two_rdy", in_ready, 1'b1);
    check("flush_two_cnt", decoded_cnt, 32'd8);
    // Flush from ONE while an input is accepted: input dropped
    drive_addi(23);
    in_valid = 1'b1;
    step();
    drive_addi(24);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_one_vld", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_one_empty", out_valid, 1'b0);

    // Decode vector table, one instruction at a time into an empty stage
    for (int i = 0; i < 13; i++) begin
      ex = tbl[i].e;
      ex.pc = 32'h1000 + 32'(i * 4);
      cur_exp = ex;
      in_ir = tbl[i].ir;
      in_pc = ex.pc;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("lat_%0d", i), out_valid, 1'b1);
      drain($sformatf("drain_%0d", i));
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    check("tbl_cnt", decoded_cnt, 32'd21);

    // ECALL with a younger addi in the skid buffer
    out_ready = 1'b0;
    in_ir = 32'h00000073;
    in_pc = 32'h3000;
    ex = tbl[12].e;
    ex.pc = 32'h3000;
    cur_exp = ex;
    in_valid = 1'b1;
    step();
    drive_addi(9);
    step();
    in_valid = 1'b0;
    check("halt_two_rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("halt_vld", out_valid, 1'b0);
    check("halt_rdy", in_ready, 1'b0);
    drive_addi(10);
    in_valid = 1'b1;
    mism = 0;
    repeat (5) begin
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b0) mism++;
    end
    check("halt_sticky", mism, 0);
    check("halt_cnt", decoded_cnt, 32'd22);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("halt_rst_rdy", in_ready, 1'b1);
    check("halt_rst_cnt", decoded_cnt, 32'd0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
